apb_mem_responder: RTL

APB_MEM_RESPONDER -- requirements
Module: apb_mem_responder

---
 rtl/apb_mem_responder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/apb_mem_responder.sv
// APB memory-mapped register file responder.
// Two-state FSM (IDLE/ACCESS) with registered setup-phase capture, byte-strobed
// writes, and error response on out-of-range or misaligned addresses.
// Optional wait-state insertion is compiled in with APB_MEM_RESPONDER_WAIT_EN;
// without it every transfer completes in its first access cycle.
module apb_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_WORDS   = 16,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                            clk_i,
  input  logic                            arst_ni,
  input  logic                            psel_i,
  input  logic                            penable_i,
  input  logic [ADDR_WIDTH-1:0]           paddr_i,
  input  logic                            pwrite_i,
  input  logic [DATA_WIDTH-1:0]           pwdata_i,
  input  logic [DATA_WIDTH/8-1:0]         pstrb_i,
  output logic                            pready_o,
  output logic [DATA_WIDTH-1:0]           prdata_o,
  output logic                            pslverr_o,
  output logic [NUM_WORDS*DATA_WIDTH-1:0] regs_o
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFFS  = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [BYTES-1:0]        strb_q;
  logic [DATA_WIDTH-1:0]   mem_q [NUM_WORDS];

  logic                    setup;
  logic                    ready;
  logic                    cnt_zero;
  logic                    err;
  logic                    commit;
  logic [ADDR_WIDTH-1:0]   idx_full;
  logic [IDX_W-1:0]        word_idx;

  // State register
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and completion decode
  always_comb begin
    state_d = state_q;
    setup   = 1'b0;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        // psel with penable and no preceding setup is ignored
        if (psel_i && !penable_i) begin
          state_d = ACCESS;
          setup   = 1'b1;
        end
      end
      ACCESS: begin
        if (!psel_i) begin
          state_d = IDLE;
        end else if (penable_i && cnt_zero) begin
          ready   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef APB_MEM_RESPONDER_WAIT_EN
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  logic [CNT_W-1:0] cnt_q;

  // Wait-state counter: loaded at setup, counts down during access cycles
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      cnt_q <= '0;
    end else if (setup) begin
      cnt_q <= CNT_W'(WAIT_CYCLES);
    end else if (state_q == ACCESS && psel_i && penable_i && !cnt_zero) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign cnt_zero = (cnt_q == '0);
`else
  assign cnt_zero = 1'b1;
`endif

  // Capture the transfer attributes at the setup edge
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (setup) begin
      addr_q  <= paddr_i;
      write_q <= pwrite_i;
      wdata_q <= pwdata_i;
      strb_q  <= pstrb_i;
    end
  end

  // Address decode from captured address only
  assign idx_full = addr_q >> OFFS;
  assign word_idx = idx_full[IDX_W-1:0];
  assign err      = (idx_full >= ADDR_WIDTH'(NUM_WORDS)) ||
                    ((addr_q & ADDR_WIDTH'(BYTES - 1)) != '0);
  assign commit   = ready && write_q && !err;

  // Register file with per-byte write enables
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int k = 0; k < int'(NUM_WORDS); k++) begin
        mem_q[k] <= '0;
      end
    end else if (commit) begin
      for (int b = 0; b < int'(BYTES); b++) begin
        if (strb_q[b]) begin
          mem_q[word_idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
        end
      end
    end
  end

  // Completion response; read data is zero outside a good read completion
  assign pready_o  = ready;
  assign pslverr_o = ready && err;
  assign prdata_o  = (ready && !write_q && !err) ? mem_q[word_idx] : '0;

  // Flatten register file for observation
  always_comb begin
    regs_o = '0;
    for (int k = 0; k < int'(NUM_WORDS); k++) begin
      regs_o[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[k];
    end
  end

endmodule
